// File: rtl/spi_reg_target_pkg.sv
// Shared types and constants for the SPI register target: FSM state encoding,
// command-byte layout and synchronizer depth.
package spi_reg_target_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam int CMD_RNW_BIT = 7;
  localparam int BIT_CNT_W   = 3;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_reg_target_if.sv
// Byte-wide register bus between the SPI target (master side) and the
// control/status register block (slave side).
interface spi_reg_target_if #(
  parameter int ADDR_W = 7
);

  logic [ADDR_W-1:0] bus_addr_o;
  logic [7:0]        bus_wdata_o;
  logic              bus_we_o;
  logic              bus_re_o;
  logic [7:0]        bus_rdata_i;

  // Handshake: bus_we_o/bus_re_o are single-cycle strobes with no backpressure;
  // the address (and write data) is valid while the strobe is high and stays
  // stable between strobes; bus_rdata_i must be valid the cycle after bus_re_o.
  modport master (
    output bus_addr_o,
    output bus_wdata_o,
    output bus_we_o,
    output bus_re_o,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_addr_o,
    input  bus_wdata_o,
    input  bus_we_o,
    input  bus_re_o,
    output bus_rdata_i
  );

endinterface

// File: rtl/spi_tgt_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with registered
// single-cycle rise/fall pulses taken from the synchronized level.
module spi_tgt_sync
  import spi_reg_target_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      q_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], d};
      q_d  <= sr[SYNC_STAGES-1];
      rise <= sr[SYNC_STAGES-1] & ~q_d;
      fall <= ~sr[SYNC_STAGES-1] & q_d;
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 responder turning command/data frames into register-bus strobes.
// Define SPI_REG_TARGET_AUTOINC_EN to auto-increment the address per data byte.
module spi_reg_target
  import spi_reg_target_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              spi_ssel_i,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  spi_reg_target_if.master  bus,
  output logic              busy_o,
  output state_t            dbg_state_o
);

  logic ssel_q, ssel_rise, ssel_fall;
  logic sck_q, sck_rise, sck_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_tgt_sync u_sync_ssel (.clk(clk_i), .rst_n(rst_n_i), .d(spi_ssel_i),
                            .q(ssel_q), .rise(ssel_rise), .fall(ssel_fall));
  spi_tgt_sync u_sync_sck  (.clk(clk_i), .rst_n(rst_n_i), .d(spi_sck_i),
                            .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_tgt_sync u_sync_mosi (.clk(clk_i), .rst_n(rst_n_i), .d(spi_mosi_i),
                            .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_sync;
  assign unused_sync = ^{sck_q, mosi_rise, mosi_fall};

  state_t                state, state_n;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [7:0]            rx_sr, rx_n, tx_sr, tx_n, wdata, wdata_n;
  logic [ADDR_W-1:0]     addr, addr_n;
  logic                  we, we_n, re, re_n, re_d, armed;
  logic [7:0]            rx_shift;
  logic                  byte_done;

  assign rx_shift  = {rx_sr[6:0], mosi_q};
  assign byte_done = sck_rise && (bit_cnt == '1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      addr    <= '0;
      wdata   <= '0;
      we      <= 1'b0;
      re      <= 1'b0;
      re_d    <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      rx_sr   <= rx_n;
      tx_sr   <= tx_n;
      addr    <= addr_n;
      wdata   <= wdata_n;
      we      <= we_n;
      re      <= re_n;
      re_d    <= re;
      // Synchronizers reset to "selected"; only a genuinely observed high ssel
      // arms the block, so a frame in flight across reset is ignored.
      armed   <= armed | ssel_q;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_n      = rx_sr;
    tx_n      = tx_sr;
    addr_n    = addr;
    wdata_n   = wdata;
    we_n      = 1'b0;
    re_n      = 1'b0;
`ifdef SPI_REG_TARGET_AUTOINC_EN
    if (we) addr_n = addr + ADDR_W'(1);
`endif
    case (state)
      IDLE: begin
        if (ssel_fall) begin
          state_n   = CMD;
          bit_cnt_n = '0;
          rx_n      = '0;
          tx_n      = '0;
        end
      end
      default: begin
        if (re_d && state == RDATA) tx_n = bus.bus_rdata_i;
        // The falling edge right after a byte boundary must keep the freshly
        // loaded MSB, so only intra-byte falls shift.
        if (sck_fall && state == RDATA && bit_cnt != '0) tx_n = {tx_sr[6:0], 1'b0};
        if (sck_rise) begin
          rx_n      = rx_shift;
          bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              addr_n = rx_shift[ADDR_W-1:0];
              if (rx_shift[CMD_RNW_BIT]) begin
                state_n = RDATA;
                re_n    = 1'b1;
              end else begin
                state_n = WDATA;
              end
            end
            WDATA: begin
              we_n    = 1'b1;
              wdata_n = rx_shift;
            end
            RDATA: begin
              re_n = 1'b1;
`ifdef SPI_REG_TARGET_AUTOINC_EN
              addr_n = addr + ADDR_W'(1);
`endif
            end
            default: ;
          endcase
        end
        if (ssel_rise) begin
          state_n = IDLE;
          tx_n    = '0;
        end
      end
    endcase
  end

  assign bus.bus_addr_o  = addr;
  assign bus.bus_wdata_o = wdata;
  assign bus.bus_we_o    = we;
  assign bus.bus_re_o    = re;
  assign spi_miso_o      = tx_sr[7];
  assign spi_miso_oe_o   = armed & ~ssel_q;
  assign busy_o          = (state != IDLE);
  assign dbg_state_o     = state;

endmodule

// File: doc/spi_reg_target.md
# spi_reg_target

SPI mode-0 responder that turns frames from the design's SPI master into single-cycle register-bus accesses. It sits on the FPGA side of an SPI link and exposes a simple byte-wide read/write port to control/status registers. All SPI pins are oversampled in the single system clock domain.

## Interface
Parameters:
- ADDR_W, 7: register address width, 1..7; the address space is 2^ADDR_W bytes.

Ports:
- clk_i  in  1  system clock; all logic is on its rising edge. Single clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- spi_ssel_i  in  1  chip select, active low, asynchronous to clk_i.
- spi_sck_i  in  1  SPI clock, asynchronous to clk_i.
- spi_mosi_i  in  1  serial data from the master.
- spi_miso_o  out  1  serial data to the master.
- spi_miso_oe_o  out  1  MISO output enable, high while selected; the top level does the tristating.
- bus_addr_o  out  ADDR_W  register address.
- bus_wdata_o  out  8  write data.
- bus_we_o  out  1  one-cycle write strobe.
- bus_re_o  out  1  one-cycle read strobe.
- bus_rdata_i  in  8  read data; it must be valid on the cycle after bus_re_o.
- busy_o  out  1  high while a frame is active (state not IDLE).

## Operation
- Protocol: CPOL=0, CPHA=0, MSB first. MOSI is sampled on SCK rising edges; MISO changes on SCK falling edges.
- Synchronization: ssel, sck and mosi each pass through a 2-flop synchronizer, then a rising/falling edge detect on the synchronized sck.
- Frame format:
  - Byte 0 is the command. Bit 7 is R/nW (1 = read); bits [ADDR_W-1:0] are the start address. Unused address bits are ignored.
  - Bytes 1..N are data bytes.
- State machine (state_t): IDLE, CMD, WDATA, RDATA.
  - IDLE→CMD: synchronized ssel falls. The bit counter clears and the shift registers clear.
  - CMD→WDATA: 8th bit received with R/nW=0. The address register is loaded.
  - CMD→RDATA: 8th bit received with R/nW=1. The address register is loaded and bus_re_o pulses.
  - WDATA: each 8th bit pulses bus_we_o with the received byte on bus_wdata_o, then the address increments.
  - RDATA:
    - bus_rdata_i is captured into the TX shift register on the cycle after bus_re_o.
    - The MSB drives MISO immediately; later bits shift out on each falling edge.
    - On each 8th rising edge the address increments and bus_re_o pulses to prefetch the next byte.
  - Any state→IDLE: synchronized ssel rises. A partial byte is discarded with no bus strobe.
- MISO is 0 during the command byte.
- Address arithmetic: increments modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- The bus address is held stable between strobes.
- A read prefetch issued at the end of a frame is harmless; extra reads are tolerated by design.

## Timing
- Reset values: spi_miso_o=0, spi_miso_oe_o=0, bus_we_o=0, bus_re_o=0, bus_addr_o=0, bus_wdata_o=0, busy_o=0, state IDLE.
- Input-to-action latency is 3 clk_i cycles from a pin edge: 2 synchronizer cycles plus 1 edge-detect cycle.
- Strobes are asserted 1 cycle after the 8th detected rising edge.
- The first read byte's MSB is on MISO 2 cycles after bus_re_o.
- The SCK high and low phases must each be ≥8 clk_i cycles, i.e. f_sck ≤ f_clk/16. This guarantees read data is present before the next falling edge.
- If ssel rise and an 8th-bit completion are detected in the same cycle, the byte completion wins: the strobe is issued, then the block goes to IDLE.
- spi_miso_oe_o follows the synchronized, inverted ssel.
- Async reset mid-frame:
  - All state clears immediately with no strobe.
  - After reset release the block waits for a fresh ssel falling edge. A frame already in progress is ignored until ssel goes high.

## Configuration
- SPI_REG_TARGET_AUTOINC_EN defined: the address increments after every data byte, as described above.
- SPI_REG_TARGET_AUTOINC_EN undefined:
  - The address stays fixed for the whole frame, so every write goes to the command address.
  - Every read prefetch re-reads the command address, which allows FIFO-style polling of one register.

## Structure
- Package spi_reg_target_pkg:
  - state_t enum.
  - CMD_RNW_BIT=7.
  - BIT_CNT_W=3.
  - SYNC_STAGES=2.
- Sub-module spi_tgt_sync, instantiated once per pin:
  - Generic 2-flop synchronizer with registered rise and fall pulse outputs.
  - Reset is async active-low.

## Test plan
- Write frame 0x05, 0xA1, 0xB2 → bus_we_o twice: addr 0x05 with data 0xA1, then addr 0x06 with data 0xB2. No bus_re_o.
- Read frame 0x83 plus two dummy bytes, with a bus model holding [3]=0x5C and [4]=0x77 → MISO returns 0x00, 0x5C, 0x77. bus_re_o pulses at addr 3, 4 and 5.
- Abort: ssel rises after 5 bits of data byte 1 in a write frame → no bus_we_o, busy_o=0 within 4 cycles, next frame decodes normally.
- Wrap with ADDR_W=4: write 0x0F, 0x11, 0x22 → writes to addr 0x0F then 0x00.
- rst_n_i pulsed low mid-byte in a read frame → all outputs return to reset values at once. The remainder of that frame causes no strobes; the next frame works.
- Build without SPI_REG_TARGET_AUTOINC_EN: write 0x02, 0x10, 0x20 → both writes go to addr 0x02.
